// File: rtl/elastic_stage_reg.sv
// elastic_stage_reg: pipeline stage register with valid/ready handshake,
// flush (clears control to a bubble) and freeze (global hold).
// Optional two-entry skid buffer enabled by `define ELASTIC_STAGE_SKID_EN.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   flush, freeze            - discard held entries / hold everything
//   in_valid, in_ready       - upstream handshake
//   in_ctrl, in_data         - incoming control and data fields
//   out_valid, out_ready     - downstream handshake
//   out_ctrl, out_data       - head entry (always the main register)
//   occupancy                - number of held entries (0..2)
module elastic_stage_reg #(
    parameter int CTRL_W = 8,
    parameter int DATA_W = 96
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              freeze,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
`ifdef ELASTIC_STAGE_SKID_EN
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
`endif

    logic acc;
    logic pop;

    // State and storage registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            main_ctrl_q <= '0;
            main_data_q <= '0;
`ifdef ELASTIC_STAGE_SKID_EN
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
`ifdef ELASTIC_STAGE_SKID_EN
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
`endif
        end
    end

    // Next-state and next-storage logic
    always_comb begin
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
`ifdef ELASTIC_STAGE_SKID_EN
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;
`endif
        if (flush) begin
            // Control becomes a bubble; data is left as-is
            state_d     = EMPTY;
            main_ctrl_d = '0;
`ifdef ELASTIC_STAGE_SKID_EN
            skid_ctrl_d = '0;
`endif
        end else if (!freeze) begin
            unique case (state_q)
                EMPTY: begin
                    if (acc) begin
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                        state_d     = ONE;
                    end
                end
                ONE: begin
                    if (acc && pop) begin
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
`ifdef ELASTIC_STAGE_SKID_EN
                    end else if (acc) begin
                        skid_ctrl_d = in_ctrl;
                        skid_data_d = in_data;
                        state_d     = TWO;
`endif
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
`ifdef ELASTIC_STAGE_SKID_EN
                TWO: begin
                    if (pop) begin
                        main_ctrl_d = skid_ctrl_q;
                        main_data_d = skid_data_q;
                        state_d     = ONE;
                    end
                end
`endif
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    // Outputs and handshake
    always_comb begin
        out_valid = (state_q != EMPTY) && !freeze;
`ifdef ELASTIC_STAGE_SKID_EN
        // Depends only on registered state, never on out_ready
        in_ready  = !rst && !flush && !freeze && (state_q != TWO);
`else
        // Single entry: refill in the same cycle the head is consumed
        in_ready  = !rst && !flush && !freeze
                    && ((state_q == EMPTY) || out_ready);
`endif
        acc       = in_valid && in_ready;
        pop       = out_valid && out_ready;
        out_ctrl  = main_ctrl_q;
        out_data  = main_data_q;
        occupancy = state_q;
    end

endmodule

// File: doc/elastic_stage_reg.md
# elastic_stage_reg

Parametrised pipeline stage register with a valid/ready handshake, flush and freeze, used between ARM pipeline stages (IF→ID, ID→EXE, EXE→MEM, MEM→WB). It holds a control field, cleared to a bubble on flush, and a data field. An optional two-entry skid buffer gives full throughput with a registered `in_ready`. It replaces the fixed, always-advancing stage registers: a stage can now stall independently of global freeze without losing an instruction.

## Interface
Parameters:
- `CTRL_W`, default 8: width of the control field (WB_EN, MEM_R_EN, MEM_W_EN, B, S, EXE_CMD…). It is zeroed on flush and on reset.
- `DATA_W`, default 96: width of the data field (PC, Val_Rn, Val_Rm, immediates…). It is zeroed on reset only.

Ports:
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `flush` in 1: discard all held entries (branch taken).
- `freeze` in 1: global hold (SRAM wait).
- `in_valid` in 1: upstream offers an entry.
- `in_ready` out 1: stage accepts an entry this cycle.
- `in_ctrl` in CTRL_W: incoming control field.
- `in_data` in DATA_W: incoming data field.
- `out_valid` out 1: the head entry is presented.
- `out_ready` in 1: downstream consumes the head.
- `out_ctrl` out CTRL_W: head control field.
- `out_data` out DATA_W: head data field.
- `occupancy` out 2: number of held entries (0–2).

## Operation
- Accept: `acc = in_valid & in_ready`.
- Pop: `pop = out_valid & out_ready`.
- Storage is a main register (head) plus a skid register. The states are EMPTY, ONE and TWO; `occupancy` is 0, 1 or 2 respectively.
- Transitions when there is no flush and no freeze:
  - EMPTY: on `acc`, the entry goes to main and the state becomes ONE.
  - ONE, `acc & !pop`: the entry goes to skid and the state becomes TWO.
  - ONE, `acc & pop`: the entry goes to main and the state stays ONE.
  - ONE, `pop & !acc`: the state becomes EMPTY.
  - TWO, `pop`: skid moves to main and the state becomes ONE. No accept is possible in TWO.
- Priority is `rst` > `flush` > `freeze` > handshake.
- Flush:
  - Next state is EMPTY, and `out_ctrl` register and skid ctrl become 0.
  - Data registers hold their values.
  - The entry offered in the flush cycle is dropped: `in_ready` is 0 during flush.
- Freeze:
  - All registers hold.
  - `in_ready` is 0 and `out_valid` is 0, so no transfer occurs.
  - The head reappears when freeze drops.
- `out_valid = (state != EMPTY) & !freeze`.
- `out_ctrl` and `out_data` always come directly from the main register and are stable while `out_valid & !out_ready`.
- `in_ready` never depends combinationally on `out_ready` (with skid enabled).

## Timing
- Reset values:
  - State is EMPTY; `out_valid` 0, `out_ctrl` 0, `out_data` 0, skid registers 0, `occupancy` 0.
  - `in_ready` is 0 while `rst` is high and 1 on the first cycle after.
- Latency is 1 cycle: an entry accepted on edge N is on `out_*` with `out_valid=1` after edge N.
- Throughput is 1 entry/cycle when `out_ready` is held high.
- With skid enabled, `in_ready = !rst & !flush & !freeze & (state != TWO)`. The state term is registered.
- Reset asserted mid-transfer: both entries are lost and no output is presented in the following cycle.
- `flush` and `freeze` in the same cycle: flush wins and the state becomes EMPTY.
- `pop` and `flush` in the same cycle: downstream sees the pop and must apply its own flush; the stage still empties.

## Configuration
- `ELASTIC_STAGE_SKID_EN` defined:
  - Two-entry skid as above; `occupancy` can reach 2.
  - `in_ready` is registered with respect to `out_ready`.
- `ELASTIC_STAGE_SKID_EN` undefined:
  - Single entry, no skid registers; state is EMPTY or ONE and `occupancy` is at most 1.
  - `in_ready = !rst & !flush & !freeze & ((state == EMPTY) | out_ready)`, which is a combinational path from `out_ready`.
  - Throughput is still 1/cycle.

## Test plan
- Reset, then stream `in_ctrl` 0x01..0x10 with `out_ready=1` → `out_ctrl` 0x01..0x10 on consecutive cycles, 1-cycle latency, `occupancy` 1.
- Backpressure: `out_ready=0` for 3 cycles while `in_valid=1` → with skid, `occupancy` goes to 2 and `in_ready=0` from the 2nd cycle; without skid, `in_ready=0` from the 1st. Release → in-order output with no loss or duplicate.
- Flush while in TWO with ctrl 0x11/0x22 held → next cycle `occupancy` 0, `out_valid` 0, `out_ctrl` 0; the entry offered in the flush cycle never appears.
- Freeze for 4 cycles with head 0x33 and `out_ready=1` → `out_valid` 0, `in_ready` 0, all registers unchanged; 0x33 is output in the first cycle after freeze drops.
- Simultaneous flush+freeze, then `rst` pulsed mid-stream → EMPTY after each; after reset all outputs are 0 and `in_ready` returns to 1 one cycle later.
